// File: rtl/forprop_sched.sv
// Forward-propagation sequencer for a two-layer MLP: walks weight and activation
// addresses neuron by neuron and strobes the MAC and activation write-back.
module forprop_sched #(
    parameter int IMG_SIZE = 256,
    parameter int HIDDEN   = 32,
    parameter int CLASSES  = 10,
    localparam int WA_W = $clog2(IMG_SIZE*HIDDEN + HIDDEN*CLASSES),
    localparam int XA_W = $clog2(IMG_SIZE),
    localparam int NA_W = $clog2(HIDDEN)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_forprop,
    output logic            forprop_done,
    output logic            busy,
    output logic            layer,
    output logic            rd_en,
    output logic [WA_W-1:0] w_addr,
    output logic [XA_W-1:0] x_addr,
    output logic            mac_clr,
    output logic            mac_en,
    output logic            y_we,
    output logic [NA_W-1:0] y_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_layer;
    logic [NA_W-1:0] r_n;
    logic [XA_W-1:0] r_i;
    logic [WA_W-1:0] r_wptr;
    logic            r_mac_en_p1;
    logic [XA_W-1:0] r_x_hold;
    logic [WA_W-1:0] r_w_hold;
    logic [NA_W-1:0] r_y_hold;

    logic            w_rd;
    logic            w_clr;
    logic            w_we;
    logic            w_done;
    logic            w_abort;
    logic [XA_W-1:0] w_last_i;
    logic [NA_W-1:0] w_last_n;

    always_comb begin
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        w_clr       = 1'b0;
        w_we        = 1'b0;
        w_done      = 1'b0;
        w_last_i    = r_layer ? XA_W'(HIDDEN - 1)  : XA_W'(IMG_SIZE - 1);
        w_last_n    = r_layer ? NA_W'(CLASSES - 1) : NA_W'(HIDDEN - 1);
        w_abort     = !start_forprop &&
                      (r_state == S_CLR || r_state == S_RUN ||
                       r_state == S_DRAIN || r_state == S_WRITE);
        case (r_state)
            S_IDLE:  if (start_forprop) w_state_nxt = S_CLR;
            S_CLR: begin
                w_clr       = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_rd = 1'b1;
                if (r_i == w_last_i) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: w_state_nxt = S_WRITE;
            S_WRITE: begin
                w_we = 1'b1;
                if (r_n == w_last_n && r_layer) w_state_nxt = S_DONE;
                else                            w_state_nxt = S_CLR;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A dropped request suppresses the write-back in the same cycle.
        if (w_abort) begin
            w_state_nxt = S_IDLE;
            w_we        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_layer     <= 1'b0;
            r_n         <= '0;
            r_i         <= '0;
            r_wptr      <= '0;
            r_mac_en_p1 <= 1'b0;
            r_x_hold    <= '0;
            r_w_hold    <= '0;
            r_y_hold    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mac_en_p1 <= w_rd;
            if (w_rd) begin
                r_x_hold <= r_i;
                r_w_hold <= r_wptr;
            end
            if (w_we) r_y_hold <= r_n;
            if (w_abort) begin
                r_layer <= 1'b0;
                r_n     <= '0;
                r_i     <= '0;
                r_wptr  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_forprop) begin
                            r_layer <= 1'b0;
                            r_n     <= '0;
                            r_i     <= '0;
                            r_wptr  <= '0;
                        end
                    end
                    S_RUN: begin
                        // wptr never rewinds: layer-1 weights follow layer-0 weights.
                        r_wptr <= r_wptr + 1'b1;
                        r_i    <= (r_i == w_last_i) ? '0 : r_i + 1'b1;
                    end
                    S_WRITE: begin
                        if (r_n != w_last_n) begin
                            r_n <= r_n + 1'b1;
                        end else if (!r_layer) begin
                            r_layer <= 1'b1;
                            r_n     <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign forprop_done = w_done;
    assign busy         = (r_state != S_IDLE);
    assign layer        = r_layer;
    assign rd_en        = w_rd;
    assign mac_clr      = w_clr;
    assign mac_en       = r_mac_en_p1;
    assign y_we         = w_we;
    assign w_addr       = w_rd ? r_wptr : r_w_hold;
    assign x_addr       = w_rd ? r_i    : r_x_hold;
    assign y_addr       = w_we ? r_n    : r_y_hold;

endmodule

// File: tb/tb_forprop_sched.sv
// Bench for forprop_sched with a 4-3-2 network: scenario table plus abort and
// asynchronous-reset sequences, with an address/write-back scoreboard.
module tb_forprop_sched;

    localparam int IMG_SIZE = 4;
    localparam int HIDDEN   = 3;
    localparam int CLASSES  = 2;
    localparam int WA_W     = 5;
    localparam int XA_W     = 2;
    localparam int NA_W     = 2;
    localparam int PASS_EDGES = HIDDEN*(IMG_SIZE+3) + CLASSES*(HIDDEN+3);

    logic            clk = 1'b0;
    logic            reset;
    logic            start_forprop;
    logic            forprop_done;
    logic            busy;
    logic            layer;
    logic            rd_en;
    logic [WA_W-1:0] w_addr;
    logic [XA_W-1:0] x_addr;
    logic            mac_clr;
    logic            mac_en;
    logic            y_we;
    logic [NA_W-1:0] y_addr;

    forprop_sched #(.IMG_SIZE(IMG_SIZE), .HIDDEN(HIDDEN), .CLASSES(CLASSES)) dut (
        .clk(clk), .reset(reset), .start_forprop(start_forprop),
        .forprop_done(forprop_done), .busy(busy), .layer(layer), .rd_en(rd_en),
        .w_addr(w_addr), .x_addr(x_addr), .mac_clr(mac_clr), .mac_en(mac_en),
        .y_we(y_we), .y_addr(y_addr)
    );

    always #5 clk = ~clk;

    typedef struct { logic [WA_W-1:0] w; logic [XA_W-1:0] x; } rd_t;
    typedef struct { logic l; logic [NA_W-1:0] a; } wr_t;
    typedef struct { bit keep; bit exp_restart; int exp_mac; int exp_done; } scn_t;

    rd_t q_rd[$];
    wr_t q_wr[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  mac_total  = 0;
    int  done_total = 0;
    rd_t e_rd;
    wr_t e_wr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every read and write-back strobe is matched in order.
    always @(negedge clk) begin
        if (rd_en) begin
            if (q_rd.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
            else begin
                e_rd = q_rd.pop_front();
                chk("w_addr", 32'(w_addr), 32'(e_rd.w));
                chk("x_addr", 32'(x_addr), 32'(e_rd.x));
            end
        end
        if (y_we) begin
            if (q_wr.size() == 0) chk("y_we_unexpected", 32'd1, 32'd0);
            else begin
                e_wr = q_wr.pop_front();
                chk("y_layer", 32'(layer), 32'(e_wr.l));
                chk("y_addr", 32'(y_addr), 32'(e_wr.a));
            end
        end
        if (rd_en | mac_clr | y_we | forprop_done)
            chk("strobe_excl", 32'(rd_en) + 32'(mac_clr) + 32'(y_we) + 32'(forprop_done), 32'd1);
        if (mac_en) mac_total++;
        if (forprop_done) done_total++;
    end

    task automatic push_pass();
        int wp;
        wp = 0;
        for (int n = 0; n < HIDDEN; n++) begin
            for (int i = 0; i < IMG_SIZE; i++) begin
                q_rd.push_back('{w: WA_W'(wp), x: XA_W'(i)});
                wp++;
            end
            q_wr.push_back('{l: 1'b0, a: NA_W'(n)});
        end
        for (int n = 0; n < CLASSES; n++) begin
            for (int i = 0; i < HIDDEN; i++) begin
                q_rd.push_back('{w: WA_W'(wp), x: XA_W'(i)});
                wp++;
            end
            q_wr.push_back('{l: 1'b1, a: NA_W'(n)});
        end
    endtask

    // Counts edges from the CLR cycle until forprop_done is seen.
    task automatic wait_done(output int edges);
        edges = 0;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (forprop_done) return;
        end
        chk("done_timeout", 32'd1, 32'd0);
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_done"},   32'(forprop_done), 0);
        chk({pfx, "_busy"},   32'(busy), 0);
        chk({pfx, "_layer"},  32'(layer), 0);
        chk({pfx, "_rd_en"},  32'(rd_en), 0);
        chk({pfx, "_mac_clr"},32'(mac_clr), 0);
        chk({pfx, "_mac_en"}, 32'(mac_en), 0);
        chk({pfx, "_y_we"},   32'(y_we), 0);
        chk({pfx, "_w_addr"}, 32'(w_addr), 0);
        chk({pfx, "_x_addr"}, 32'(x_addr), 0);
        chk({pfx, "_y_addr"}, 32'(y_addr), 0);
    endtask

    task automatic run_scn(input scn_t s);
        int m0, d0, edges;
        m0 = mac_total;
        d0 = done_total;
        push_pass();
        if (s.keep) push_pass();
        @(negedge clk); #1 start_forprop = 1'b1;
        @(negedge clk);
        chk("clr_after_start", 32'(mac_clr), 1);
        chk("busy_in_clr", 32'(busy), 1);
        wait_done(edges);
        chk("pass_edges", 32'(edges), 32'(PASS_EDGES));
        if (!s.keep) #1 start_forprop = 1'b0;
        @(negedge clk);
        chk("done_width", 32'(forprop_done), 0);
        chk("idle_after_done", 32'(busy), 0);
        @(negedge clk);
        chk("restart_clr", 32'(mac_clr), 32'(s.exp_restart));
        chk("restart_busy", 32'(busy), 32'(s.exp_restart));
        if (s.exp_restart) begin
            wait_done(edges);
            chk("pass2_edges", 32'(edges), 32'(PASS_EDGES));
            #1 start_forprop = 1'b0;
            @(negedge clk);
        end
        @(negedge clk);
        chk("stays_idle", 32'(busy), 0);
        chk("mac_count", 32'(mac_total - m0), 32'(s.exp_mac));
        chk("done_count", 32'(done_total - d0), 32'(s.exp_done));
        chk("rd_queue_left", 32'(q_rd.size()), 0);
        chk("wr_queue_left", 32'(q_wr.size()), 0);
        chk("w_addr_hold", 32'(w_addr), 17);
        chk("x_addr_hold", 32'(x_addr), 2);
        chk("y_addr_hold", 32'(y_addr), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        scn_t tbl[2];
        int   m0, d0;
        bit   found;
        tbl[0] = '{keep: 1'b0, exp_restart: 1'b0, exp_mac: 18, exp_done: 1};
        tbl[1] = '{keep: 1'b1, exp_restart: 1'b1, exp_mac: 36, exp_done: 2};

        reset = 1'b1;
        start_forprop = 1'b0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_action_busy", 32'(busy), 0);
        chk("no_action_rd", 32'(rd_en), 0);

        for (int t = 0; t < 2; t++) run_scn(tbl[t]);

        // Abort during layer-0 RUN at i=2.
        m0 = mac_total;
        d0 = done_total;
        for (int i = 0; i < 3; i++) q_rd.push_back('{w: WA_W'(i), x: XA_W'(i)});
        @(negedge clk); #1 start_forprop = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            @(negedge clk);
            if (rd_en && x_addr == 2 && !layer) found = 1'b1;
        end
        chk("abort_found_i2", 32'(found), 1);
        #1 start_forprop = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_pending_mac", 32'(mac_en), 1);
        repeat (10) @(negedge clk);
        chk("abort_mac_count", 32'(mac_total - m0), 3);
        chk("abort_no_done", 32'(done_total - d0), 0);
        chk("abort_rd_left", 32'(q_rd.size()), 0);
        chk("abort_w_hold", 32'(w_addr), 2);

        // Asynchronous reset in the first layer-1 DRAIN cycle.
        push_pass();
        @(negedge clk); #1 start_forprop = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (busy && layer && mac_en && !rd_en) found = 1'b1;
        end
        chk("drain_found", 32'(found), 1);
        #1 reset = 1'b1;
        #1 chk_all_zero("async_rst");
        q_rd.delete();
        q_wr.delete();
        start_forprop = 1'b0;
        @(negedge clk); #1 reset = 1'b0;
        run_scn(tbl[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
